// File: rtl/id_ex_stage_if.sv
// ID->EX handshake bundle: decode-side instruction, EX-side slot, hazard/perf status.
// master = decode/execute environment, slave = the id_ex_stage register.
interface id_ex_stage_if #(
   parameter int READ_PORTS = 2
);
   logic                       flush_i;
   logic                       id_valid_i;
   logic                       id_ready_o;
   logic [31:0]                id_pc_i;
   logic [7:0]                 id_op_i;
   logic [READ_PORTS*5-1:0]    id_raddr_i;
   logic [READ_PORTS-1:0]      id_rden_i;
   logic [READ_PORTS*32-1:0]   id_rddata_i;
   logic [4:0]                 id_waddr_i;
   logic                       id_we_i;
   logic                       id_is_load_i;
   logic                       ex_valid_o;
   logic                       ex_ready_i;
   logic [31:0]                ex_pc_o;
   logic [7:0]                 ex_op_o;
   logic [READ_PORTS*32-1:0]   ex_opnd_o;
   logic [4:0]                 ex_waddr_o;
   logic                       ex_we_o;
   logic                       ex_is_load_o;
   logic                       load_use_stall_o;
   logic [31:0]                stall_cnt_o;

   modport master (
      output flush_i, id_valid_i, id_pc_i, id_op_i, id_raddr_i, id_rden_i,
             id_rddata_i, id_waddr_i, id_we_i, id_is_load_i, ex_ready_i,
      input  id_ready_o, ex_valid_o, ex_pc_o, ex_op_o, ex_opnd_o, ex_waddr_o,
             ex_we_o, ex_is_load_o, load_use_stall_o, stall_cnt_o
   );

   modport slave (
      input  flush_i, id_valid_i, id_pc_i, id_op_i, id_raddr_i, id_rden_i,
             id_rddata_i, id_waddr_i, id_we_i, id_is_load_i, ex_ready_i,
      output id_ready_o, ex_valid_o, ex_pc_o, ex_op_o, ex_opnd_o, ex_waddr_o,
             ex_we_o, ex_is_load_o, load_use_stall_o, stall_cnt_o
   );
endinterface

// File: rtl/id_ex_stage.sv
// One-entry ID->EX pipeline register with load-use hazard bubbles and flush.
// Optional stall-cycle counter on stall_cnt_o when ID_EX_PERF_EN is defined.
module id_ex_stage #(
   parameter int READ_PORTS   = 2,
   parameter int LOAD_BUBBLES = 1
) (
   input logic         clk,
   input logic         rst,
   id_ex_stage_if.slave bus
);
   // Handshake: a transfer happens on a rising clk edge where valid & ready are
   // both high; ready may depend on valid, valid never depends on ready.
   localparam logic [1:0] PEND_INIT = 2'(LOAD_BUBBLES - 1);

   logic [4:0] pend_addr;
   logic [1:0] pend_cnt;
   logic       hz_slot;
   logic       hz_pend;
   logic       ld_qual;
   logic       stall;
   logic       id_fire;
   logic       ex_fire;

   always_comb begin
      hz_slot = 1'b0;
      hz_pend = 1'b0;
      for (int i = 0; i < READ_PORTS; i++) begin
         if (bus.id_rden_i[i] && (bus.id_raddr_i[i*5 +: 5] == bus.ex_waddr_o))
            hz_slot = 1'b1;
         if (bus.id_rden_i[i] && (bus.id_raddr_i[i*5 +: 5] == pend_addr))
            hz_pend = 1'b1;
      end
      // r0 loads never produce a value a consumer could wait for
      ld_qual = bus.ex_is_load_o & bus.ex_we_o & (bus.ex_waddr_o != 5'd0);
      hz_slot = hz_slot & bus.ex_valid_o & ld_qual;
      hz_pend = hz_pend & (pend_cnt != 2'd0) & (pend_addr != 5'd0);
   end

   assign stall   = bus.id_valid_i & (hz_slot | hz_pend) & ~bus.flush_i;
   assign ex_fire = bus.ex_valid_o & bus.ex_ready_i;
   assign id_fire = bus.id_valid_i & bus.id_ready_o;

   assign bus.load_use_stall_o = stall;
   assign bus.id_ready_o       = bus.flush_i | (~stall & (~bus.ex_valid_o | bus.ex_ready_i));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ex_valid_o   <= 1'b0;
         bus.ex_pc_o      <= '0;
         bus.ex_op_o      <= '0;
         bus.ex_opnd_o    <= '0;
         bus.ex_waddr_o   <= '0;
         bus.ex_we_o      <= 1'b0;
         bus.ex_is_load_o <= 1'b0;
         pend_addr        <= '0;
         pend_cnt         <= '0;
      end else begin
         if (bus.flush_i) begin
            bus.ex_valid_o <= 1'b0;
            pend_cnt       <= '0;
         end else begin
            if (id_fire)
               bus.ex_valid_o <= 1'b1;
            else if (ex_fire)
               bus.ex_valid_o <= 1'b0;
            // a load leaving the slot re-arms the window ahead of the countdown
            if (ex_fire && ld_qual) begin
               pend_cnt  <= PEND_INIT;
               pend_addr <= bus.ex_waddr_o;
            end else if (pend_cnt != 2'd0) begin
               pend_cnt <= pend_cnt - 2'd1;
            end
         end
         if (id_fire && !bus.flush_i) begin
            bus.ex_pc_o      <= bus.id_pc_i;
            bus.ex_op_o      <= bus.id_op_i;
            bus.ex_opnd_o    <= bus.id_rddata_i;
            bus.ex_waddr_o   <= bus.id_waddr_i;
            bus.ex_we_o      <= bus.id_we_i;
            bus.ex_is_load_o <= bus.id_is_load_i;
         end
      end
   end

`ifdef ID_EX_PERF_EN
   logic [31:0] stall_cnt;

   // saturating; flush deliberately leaves the history intact
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign bus.stall_cnt_o = stall_cnt;
`else
   assign bus.stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage: one instance with LOAD_BUBBLES=1, one with 2,
// shared stimulus, scoreboard queue of expected EX slot payloads.
module tb_id_ex_stage;
   localparam int W = 111;

   typedef struct {
      logic        flush;
      logic        vld;
      logic [31:0] pc;
      logic [7:0]  op;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [1:0]  rden;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [4:0]  wa;
      logic        we;
      logic        ld;
      logic        rdy;
      logic        e_idr;
      logic        e_stall;
      logic        e_exv;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_ex_stage_if #(.READ_PORTS(2)) bus1 ();
   id_ex_stage_if #(.READ_PORTS(2)) bus2 ();

   id_ex_stage #(.READ_PORTS(2), .LOAD_BUBBLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   id_ex_stage #(.READ_PORTS(2), .LOAD_BUBBLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int           dut_sel;
   logic         s_idr;
   logic         s_stall;
   logic         s_exv;
   logic [W-1:0] s_slot;
   logic [31:0]  s_cnt;

   always_comb begin
      if (dut_sel == 2) begin
         s_idr   = bus2.id_ready_o;
         s_stall = bus2.load_use_stall_o;
         s_exv   = bus2.ex_valid_o;
         s_slot  = {bus2.ex_opnd_o, bus2.ex_op_o, bus2.ex_we_o, bus2.ex_is_load_o,
                    bus2.ex_waddr_o, bus2.ex_pc_o};
         s_cnt   = bus2.stall_cnt_o;
      end else begin
         s_idr   = bus1.id_ready_o;
         s_stall = bus1.load_use_stall_o;
         s_exv   = bus1.ex_valid_o;
         s_slot  = {bus1.ex_opnd_o, bus1.ex_op_o, bus1.ex_we_o, bus1.ex_is_load_o,
                    bus1.ex_waddr_o, bus1.ex_pc_o};
         s_cnt   = bus1.stall_cnt_o;
      end
   end

   logic [W-1:0] exp_q[$];
   int           n_cmp = 0;
   int           n_err = 0;
   int           exp_stalls = 0;
   logic         prev_exv = 1'b0;

   vec_t tab_a[25];
   vec_t tab_b[11];

   function automatic vec_t mk(input int flush, input int vld, input int pc, input int ra0,
                               input int ra1, input int rden, input int wa, input int we,
                               input int ld, input int rdy, input int idr, input int stl,
                               input int exv);
      vec_t v;
      v.flush   = 1'(flush);
      v.vld     = 1'(vld);
      v.pc      = 32'(pc);
      v.op      = 8'($urandom_range(0, 255));
      v.ra0     = 5'(ra0);
      v.ra1     = 5'(ra1);
      v.rden    = 2'(rden);
      v.d0      = $urandom();
      v.d1      = $urandom();
      v.wa      = 5'(wa);
      v.we      = 1'(we);
      v.ld      = 1'(ld);
      v.rdy     = 1'(rdy);
      v.e_idr   = 1'(idr);
      v.e_stall = 1'(stl);
      v.e_exv   = 1'(exv);
      return v;
   endfunction

   function automatic logic [W-1:0] pack(input vec_t v);
      return {v.d1, v.d0, v.op, v.we, v.ld, v.wa, v.pc};
   endfunction

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      bus1.flush_i      = v.flush;
      bus1.id_valid_i   = v.vld;
      bus1.id_pc_i      = v.pc;
      bus1.id_op_i      = v.op;
      bus1.id_raddr_i   = {v.ra1, v.ra0};
      bus1.id_rden_i    = v.rden;
      bus1.id_rddata_i  = {v.d1, v.d0};
      bus1.id_waddr_i   = v.wa;
      bus1.id_we_i      = v.we;
      bus1.id_is_load_i = v.ld;
      bus1.ex_ready_i   = v.rdy;
      bus2.flush_i      = v.flush;
      bus2.id_valid_i   = v.vld;
      bus2.id_pc_i      = v.pc;
      bus2.id_op_i      = v.op;
      bus2.id_raddr_i   = {v.ra1, v.ra0};
      bus2.id_rden_i    = v.rden;
      bus2.id_rddata_i  = {v.d1, v.d0};
      bus2.id_waddr_i   = v.wa;
      bus2.id_we_i      = v.we;
      bus2.id_is_load_i = v.ld;
      bus2.ex_ready_i   = v.rdy;
   endtask

   // Called just after a rising edge; checks combinational outputs, then the slot after the edge.
   task automatic run_vec(input vec_t v);
      drive(v);
      #1;
      check_bit("id_ready", s_idr, v.e_idr);
      check_bit("load_use_stall", s_stall, v.e_stall);
      if (prev_exv) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: slot valid but expected queue empty (t=%0t)", $time);
         end else begin
            check_vec("ex_slot", s_slot, exp_q[0]);
         end
      end
      if (prev_exv && v.rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (v.flush) exp_q.delete();
      else if (v.vld && v.e_idr) exp_q.push_back(pack(v));
      if (v.e_stall) exp_stalls++;
      @(posedge clk);
      #1;
      check_bit("ex_valid", s_exv, v.e_exv);
      prev_exv = v.e_exv;
   endtask

   task automatic do_reset();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      prev_exv   = 1'b0;
      exp_stalls = 0;
   endtask

   task automatic check_cnt(input string name);
      logic [31:0] exp_cnt;
`ifdef ID_EX_PERF_EN
      exp_cnt = 32'(exp_stalls);
`else
      exp_cnt = 32'd0;
`endif
      check_vec(name, W'(s_cnt), W'(exp_cnt));
   endtask

   initial begin
      dut_sel = 1;
      // streaming, LOAD_BUBBLES=1 load-use, rden/r0 cases, backpressure, flush
      tab_a[0]  = mk(0, 1, 'h100, 1, 2, 3, 7, 1, 0, 1, 1, 0, 1);
      tab_a[1]  = mk(0, 1, 'h104, 3, 4, 3, 8, 1, 0, 1, 1, 0, 1);
      tab_a[2]  = mk(0, 1, 'h108, 7, 8, 3, 9, 1, 0, 1, 1, 0, 1);
      tab_a[3]  = mk(0, 1, 'h10C, 1, 0, 1, 5, 1, 1, 1, 1, 0, 1);
      tab_a[4]  = mk(0, 1, 'h110, 5, 2, 1, 10, 1, 0, 1, 0, 1, 0);
      tab_a[5]  = mk(0, 1, 'h110, 5, 2, 1, 10, 1, 0, 1, 1, 0, 1);
      tab_a[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      tab_a[7]  = mk(0, 1, 'h120, 1, 0, 1, 5, 1, 1, 1, 1, 0, 1);
      tab_a[8]  = mk(0, 1, 'h124, 5, 5, 0, 11, 1, 0, 1, 1, 0, 1);
      tab_a[9]  = mk(0, 1, 'h128, 1, 0, 1, 0, 1, 1, 1, 1, 0, 1);
      tab_a[10] = mk(0, 1, 'h12C, 0, 0, 3, 13, 1, 0, 1, 1, 0, 1);
      tab_a[11] = mk(0, 1, 'h130, 1, 0, 1, 12, 1, 1, 1, 1, 0, 1);
      tab_a[12] = mk(0, 1, 'h134, 1, 12, 2, 14, 1, 0, 1, 0, 1, 0);
      tab_a[13] = mk(0, 1, 'h134, 1, 12, 2, 14, 1, 0, 1, 1, 0, 1);
      tab_a[14] = mk(0, 1, 'h200, 1, 2, 3, 3, 1, 0, 1, 1, 0, 1);
      for (int i = 15; i < 19; i++)
         tab_a[i] = mk(0, 1, 'h204, 1, 2, 3, 4, 1, 0, 0, 0, 0, 1);
      tab_a[19] = mk(0, 1, 'h204, 1, 2, 3, 4, 1, 0, 1, 1, 0, 1);
      tab_a[20] = mk(0, 1, 'h300, 1, 0, 1, 3, 1, 1, 1, 1, 0, 1);
      tab_a[21] = mk(0, 1, 'h304, 3, 0, 1, 15, 1, 0, 0, 0, 1, 1);
      tab_a[22] = mk(1, 1, 'h304, 3, 0, 1, 15, 1, 0, 0, 1, 0, 0);
      tab_a[23] = mk(0, 1, 'h308, 3, 0, 1, 16, 1, 0, 1, 1, 0, 1);
      tab_a[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);

      // LOAD_BUBBLES=2: two-cycle stall, r6 bypass, flush while pend is armed
      tab_b[0]  = mk(0, 1, 'h400, 1, 0, 1, 5, 1, 1, 1, 1, 0, 1);
      tab_b[1]  = mk(0, 1, 'h404, 5, 0, 1, 10, 1, 0, 1, 0, 1, 0);
      tab_b[2]  = mk(0, 1, 'h404, 5, 0, 1, 10, 1, 0, 1, 0, 1, 0);
      tab_b[3]  = mk(0, 1, 'h404, 5, 0, 1, 10, 1, 0, 1, 1, 0, 1);
      tab_b[4]  = mk(0, 1, 'h408, 1, 0, 1, 5, 1, 1, 1, 1, 0, 1);
      tab_b[5]  = mk(0, 1, 'h40C, 6, 0, 1, 11, 1, 0, 1, 1, 0, 1);
      tab_b[6]  = mk(0, 1, 'h410, 1, 0, 1, 3, 1, 1, 1, 1, 0, 1);
      tab_b[7]  = mk(0, 1, 'h414, 1, 0, 1, 3, 1, 1, 1, 1, 0, 1);
      tab_b[8]  = mk(1, 1, 'h418, 3, 0, 1, 17, 1, 0, 1, 1, 0, 0);
      tab_b[9]  = mk(0, 1, 'h41C, 3, 0, 1, 18, 1, 0, 1, 1, 0, 1);
      tab_b[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);

      // reset state of both instances, sampled while rst is held
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int s = 1; s <= 2; s++) begin
         dut_sel = s;
         #1;
         check_bit("reset_ex_valid", s_exv, 1'b0);
         check_bit("reset_id_ready", s_idr, 1'b1);
         check_bit("reset_stall", s_stall, 1'b0);
         check_vec("reset_slot", s_slot, '0);
         check_vec("reset_stall_cnt", W'(s_cnt), '0);
      end

      dut_sel = 1;
      do_reset();
      for (int i = 0; i < $size(tab_a); i++) run_vec(tab_a[i]);
      check_cnt("stall_cnt_after_flush_lb1");

      dut_sel = 2;
      do_reset();
      for (int i = 0; i < $size(tab_b); i++) run_vec(tab_b[i]);
      check_cnt("stall_cnt_lb2");

      // asynchronous reset between edges clears the slot and the armed pend window
      do_reset();
      run_vec(mk(0, 1, 'h500, 1, 0, 1, 5, 1, 1, 1, 1, 0, 1));
      run_vec(mk(0, 1, 'h504, 1, 0, 1, 7, 1, 1, 1, 1, 0, 1));
      #2;
      rst = 1'b1;
      #1;
      check_bit("async_rst_ex_valid", s_exv, 1'b0);
      check_vec("async_rst_slot", s_slot, '0);
      #1;
      rst = 1'b0;
      exp_q.delete();
      prev_exv   = 1'b0;
      exp_stalls = 0;
      run_vec(mk(0, 1, 'h508, 5, 0, 1, 19, 1, 0, 1, 1, 0, 1));
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      check_cnt("stall_cnt_after_async_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID→EX pipeline register placed directly downstream of the decode-stage operand forwarding logic. It captures the forwarded operands and the decoded control for one instruction and presents them to the execute stage over a valid/ready handshake. It also detects load-use hazards that EX-stage forwarding cannot resolve, and inserts bubbles for them. Flush support is included for branch/exception redirect.

Parameters:
READ_PORTS, 2, number of source operands per instruction (matches the forwarding block).
LOAD_BUBBLES, 1, number of bubbles required between a load and a dependent consumer (legal range 1..3).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush_i  in  1  discard slot contents and pending hazard state
id_valid_i  in  1  decode holds a valid instruction
id_ready_o  out  1  stage accepts the decode instruction this cycle
id_pc_i  in  32  instruction PC
id_op_i  in  8  decoded operation code
id_raddr_i  in  READ_PORTS×5  source register addresses
id_rden_i  in  READ_PORTS  source actually used
id_rddata_i  in  READ_PORTS×32  forwarded operand values
id_waddr_i  in  5  destination register
id_we_i  in  1  instruction writes a register
id_is_load_i  in  1  instruction is a load
ex_valid_o  out  1  slot valid toward EX
ex_ready_i  in  1  EX accepts the slot
ex_pc_o  out  32  registered PC
ex_op_o  out  8  registered op
ex_opnd_o  out  READ_PORTS×32  registered operands
ex_waddr_o  out  5  registered destination
ex_we_o  out  1  registered write enable
ex_is_load_o  out  1  registered load flag
load_use_stall_o  out  1  hazard stall active this cycle
stall_cnt_o  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset: all registered outputs are 0, including ex_valid_o and the payload. The pending counter is 0. id_ready_o is therefore 1 after reset.
- Slot has one entry. ex_fire = ex_valid_o & ex_ready_i. id_fire = id_valid_i & id_ready_o.
- hz_slot = ex_valid_o & ex_is_load_o & ex_we_o & ex_waddr_o≠0 & (any i: id_rden_i[i] & id_raddr_i[i]==ex_waddr_o).
- pend state: pend_addr (5 bits), pend_cnt (2 bits).
  - On an ex_fire of a qualifying load (is_load, we, waddr≠0): pend_cnt ← LOAD_BUBBLES−1 and pend_addr ← ex_waddr_o.
  - Otherwise, if pend_cnt≠0: pend_cnt decrements each cycle.
  - A newly loaded value takes priority over the decrement.
- hz_pend = pend_cnt≠0 & pend_addr≠0 & (any i: id_rden_i[i] & id_raddr_i[i]==pend_addr).
- load_use_stall_o = id_valid_i & (hz_slot | hz_pend) & ~flush_i.
- id_ready_o = flush_i | (~load_use_stall_o & (~ex_valid_o | ex_ready_i)).
- Slot update priority:
  1. flush_i: ex_valid_o ← 0 and pend_cnt ← 0. Any instruction presented in the flush cycle is consumed and dropped.
  2. id_fire: load the slot with all id_* fields and set ex_valid_o ← 1.
  3. ex_fire without id_fire: ex_valid_o ← 0. This creates the bubble while stalled.
  4. Otherwise: hold.
- Payload registers change only on id_fire. While ex_valid_o=1 and ex_ready_i=0, all ex_* outputs are stable.
- Latency: one cycle from id_fire to ex_valid_o. Full throughput (one instruction per cycle) when there is no hazard and ex_ready_i=1.
- Register 0 is never a hazard source, and reads with id_rden_i=0 never cause a hazard.
- Asynchronous reset mid-transfer clears the slot and the pend state immediately.

Optional Feature:
ID_EX_PERF_EN.
- Defined: stall_cnt_o is a 32-bit counter that increments on each cycle where load_use_stall_o=1. It saturates at 0xFFFFFFFF and is cleared by rst only (not by flush_i).
- Undefined: stall_cnt_o is tied to 0 and no counter flops are synthesised.

Test Plan:
- Streaming: three independent ALU instructions at PC 0x100, 0x104, 0x108 with ex_ready_i=1 → each appears on ex_* one cycle after acceptance, and load_use_stall_o stays 0.
- Load-use, LOAD_BUBBLES=1: load to r5, then a consumer with id_raddr_i[0]=5 and id_rden_i[0]=1 → one stall cycle and one bubble (ex_valid_o=0 for one cycle), then the consumer issues.
- Load-use, LOAD_BUBBLES=2: same sequence → exactly two stall cycles. A consumer of r6 instead issues without stall.
- Backpressure: ex_ready_i=0 for 4 cycles while holding PC 0x200 → ex_* stable and id_ready_o=0. When ex_ready_i rises, the next instruction loads on the same edge.
- Flush: slot holds a load to r3, pend_cnt≠0, and flush_i=1 with id_valid_i=1 → next cycle ex_valid_o=0, pend cleared, and a subsequent r3 consumer does not stall.
- Hazard edge cases and counter: a load to r0 followed by a consumer of r0 → no stall. With ID_EX_PERF_EN defined, after 3 stall cycles stall_cnt_o=3, and it remains 3 after a flush.
